// File: rtl/bcrypt_cost_sched_if.sv
// bcrypt_cost_sched_if: host and engine handshake bundle for the cost-loop sequencer.
// Optional macro BCRYPT_SCHED_PROGRESS_EN adds the 32-bit progress status signal.
interface bcrypt_cost_sched_if;
  localparam int unsigned COST_W = 5;
  localparam int unsigned MODE_W = 2;
  localparam int unsigned BLK_W  = 2;
  localparam int unsigned PROG_W = 32;

  logic              start;
  logic [COST_W-1:0] start_cost_unused_guard;
  logic [COST_W-1:0] cost;
  logic              busy;
  logic              done;
  logic              err;
  logic              ek_start;
  logic [MODE_W-1:0] ek_mode;
  logic              ek_done;
  logic              enc_start;
  logic [BLK_W-1:0]  enc_block;
  logic              enc_done;
`ifdef BCRYPT_SCHED_PROGRESS_EN
  logic [PROG_W-1:0] progress;
`endif

  // Stays constant; keeps the bundle layout identical across builds.
  assign start_cost_unused_guard = '0;

`ifdef BCRYPT_SCHED_PROGRESS_EN
  modport master (output start, cost, ek_done, enc_done,
                  input  busy, done, err, ek_start, ek_mode, enc_start, enc_block, progress);
  modport slave  (input  start, cost, ek_done, enc_done,
                  output busy, done, err, ek_start, ek_mode, enc_start, enc_block, progress);
`else
  modport master (output start, cost, ek_done, enc_done,
                  input  busy, done, err, ek_start, ek_mode, enc_start, enc_block);
  modport slave  (input  start, cost, ek_done, enc_done,
                  output busy, done, err, ek_start, ek_mode, enc_start, enc_block);
`endif
endinterface

// File: rtl/bcrypt_cost_sched.sv
// bcrypt_cost_sched: EksBlowfish cost-loop sequencer. Runs one salted key expansion,
// 2^cost (key, salt) expansion pairs, then ENC_ROUNDS passes over the ctext blocks.
// Only one engine is ever started at a time, so the shared SRAMs are never contended.
// Optional macro BCRYPT_SCHED_PROGRESS_EN adds the progress status output.
module bcrypt_cost_sched #(
  parameter int unsigned MIN_COST     = 4,
  parameter int unsigned MAX_COST     = 31,
  parameter int unsigned ENC_ROUNDS   = 64,
  parameter int unsigned CTEXT_BLOCKS = 3
) (
  input  logic              clk,
  input  logic              reset,
  bcrypt_cost_sched_if.slave bus
);
  localparam int unsigned COST_W = 5;
  localparam int unsigned RND_W  = 32;
  localparam int unsigned PASS_W = 6;
  localparam int unsigned BLK_W  = 2;
  localparam int unsigned MODE_W = 2;

  localparam logic [COST_W-1:0] MIN_C     = COST_W'(MIN_COST);
  localparam logic [COST_W-1:0] MAX_C     = COST_W'(MAX_COST);
  localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(ENC_ROUNDS - 1);
  localparam logic [BLK_W-1:0]  BLK_LAST  = BLK_W'(CTEXT_BLOCKS - 1);

  localparam logic [MODE_W-1:0] MODE_SALTED = 2'b00;
  localparam logic [MODE_W-1:0] MODE_KEY    = 2'b01;
  localparam logic [MODE_W-1:0] MODE_SALT   = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE, S_REJECT, S_SETUP, S_SETUP_W, S_KEY, S_KEY_W,
    S_SALT, S_SALT_W, S_ENC, S_ENC_W, S_FIN
  } state_e;

  state_e              state_q, state_d;
  logic [COST_W-1:0]   cost_q, cost_d;
  logic [RND_W-1:0]    rnd_q, rnd_d;
  logic [PASS_W-1:0]   pass_q, pass_d;
  logic [BLK_W-1:0]    blk_q, blk_d;

  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                ek_start_q, ek_start_d;
  logic [MODE_W-1:0]   ek_mode_q, ek_mode_d;
  logic                enc_start_q, enc_start_d;
  logic [BLK_W-1:0]    enc_block_q, enc_block_d;
`ifdef BCRYPT_SCHED_PROGRESS_EN
  logic [RND_W-1:0]    progress_q, progress_d;
`endif

  logic cost_ok;
  logic rnd_last;

  assign cost_ok  = (bus.cost >= MIN_C) && (bus.cost <= MAX_C);
  // 32-bit compare so cost 31 yields 0x7fffffff without overflow.
  assign rnd_last = (rnd_q == ((RND_W'(1) << cost_q) - RND_W'(1)));

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cost_q      <= '0;
      rnd_q       <= '0;
      pass_q      <= '0;
      blk_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      ek_start_q  <= 1'b0;
      ek_mode_q   <= MODE_SALTED;
      enc_start_q <= 1'b0;
      enc_block_q <= '0;
`ifdef BCRYPT_SCHED_PROGRESS_EN
      progress_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cost_q      <= cost_d;
      rnd_q       <= rnd_d;
      pass_q      <= pass_d;
      blk_q       <= blk_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      ek_start_q  <= ek_start_d;
      ek_mode_q   <= ek_mode_d;
      enc_start_q <= enc_start_d;
      enc_block_q <= enc_block_d;
`ifdef BCRYPT_SCHED_PROGRESS_EN
      progress_q  <= progress_d;
`endif
    end
  end

  // Next state and loop counters; engine dones only count in their own wait state.
  always_comb begin
    state_d = state_q;
    cost_d  = cost_q;
    rnd_d   = rnd_q;
    pass_d  = pass_q;
    blk_d   = blk_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (cost_ok) begin
            state_d = S_SETUP;
            cost_d  = bus.cost;
            rnd_d   = '0;
            pass_d  = '0;
            blk_d   = '0;
          end else begin
            state_d = S_REJECT;
          end
        end
      end
      S_REJECT:  state_d = S_IDLE;
      S_SETUP:   state_d = S_SETUP_W;
      S_SETUP_W: if (bus.ek_done) state_d = S_KEY;
      S_KEY:     state_d = S_KEY_W;
      S_KEY_W:   if (bus.ek_done) state_d = S_SALT;
      S_SALT:    state_d = S_SALT_W;
      S_SALT_W: begin
        if (bus.ek_done) begin
          if (rnd_last) begin
            state_d = S_ENC;
            pass_d  = '0;
            blk_d   = '0;
          end else begin
            state_d = S_KEY;
            rnd_d   = rnd_q + RND_W'(1);
          end
        end
      end
      S_ENC:     state_d = S_ENC_W;
      S_ENC_W: begin
        if (bus.enc_done) begin
          if (blk_q < BLK_LAST) begin
            state_d = S_ENC;
            blk_d   = blk_q + BLK_W'(1);
          end else if (pass_q < PASS_LAST) begin
            state_d = S_ENC;
            pass_d  = pass_q + PASS_W'(1);
            blk_d   = '0;
          end else begin
            state_d = S_FIN;
          end
        end
      end
      S_FIN:     state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output next values; engine pulses appear the cycle after their issuing state.
  always_comb begin
    busy_d      = (state_d != S_IDLE) && (state_d != S_REJECT);
    done_d      = (state_q == S_FIN) || (state_q == S_REJECT);
    err_d       = err_q;
    ek_start_d  = 1'b0;
    ek_mode_d   = ek_mode_q;
    enc_start_d = 1'b0;
    enc_block_d = enc_block_q;
    if (state_q == S_REJECT) begin
      err_d = 1'b1;
    end else if ((state_q == S_IDLE) && (state_d == S_SETUP)) begin
      err_d = 1'b0;
    end
    case (state_q)
      S_SETUP: begin
        ek_start_d = 1'b1;
        ek_mode_d  = MODE_SALTED;
      end
      S_KEY: begin
        ek_start_d = 1'b1;
        ek_mode_d  = MODE_KEY;
      end
      S_SALT: begin
        ek_start_d = 1'b1;
        ek_mode_d  = MODE_SALT;
      end
      S_ENC: begin
        enc_start_d = 1'b1;
        enc_block_d = blk_q;
      end
      default: ;
    endcase
`ifdef BCRYPT_SCHED_PROGRESS_EN
    case (state_d)
      S_KEY, S_KEY_W, S_SALT, S_SALT_W: progress_d = rnd_d;
      S_ENC, S_ENC_W: progress_d = (RND_W'(1) << cost_d) + RND_W'(pass_d);
      default:        progress_d = '0;
    endcase
`endif
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.ek_start  = ek_start_q;
  assign bus.ek_mode   = ek_mode_q;
  assign bus.enc_start = enc_start_q;
  assign bus.enc_block = enc_block_q;
`ifdef BCRYPT_SCHED_PROGRESS_EN
  assign bus.progress  = progress_q;
`endif
endmodule

// File: tb/tb_bcrypt_cost_sched.sv
// tb_bcrypt_cost_sched: scoreboard bench for the bcrypt cost-loop sequencer.
// Expected pulse streams are generated from the hashing recipe and popped by a monitor.
module tb_bcrypt_cost_sched;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_r = 1'b0;
  logic [4:0] cost_r = '0;
  logic       ek_done_r = 1'b0;
  logic       enc_done_r = 1'b0;
  logic       spur_ek = 1'b0;
  logic       spur_enc = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int start_cyc = -100;
  int eng_done_cyc = -100;
  int ek_seen = 0;
  int enc_seen = 0;
  int done_seen = 0;
  int lat_fix = 3;
  bit rand_lat = 1'b0;
  bit both_rand = 1'b0;
  int ek_cd = 0;
  int enc_cd = 0;

  int exp_ek[$];
  int exp_enc[$];
  int exp_done[$];
`ifdef BCRYPT_SCHED_PROGRESS_EN
  int exp_pek[$];
  int exp_penc[$];
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bcrypt_cost_sched_if bus();
  bcrypt_cost_sched dut (.clk(clk), .reset(reset), .bus(bus));

  assign bus.start    = start_r;
  assign bus.cost     = cost_r;
  assign bus.ek_done  = ek_done_r | spur_ek;
  assign bus.enc_done = enc_done_r | spur_enc;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic flag(string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: got an event, expected none (cycle %0d)", nm, cyc);
  endtask

  // Engine models: answer each start after a fixed or random latency.
  initial begin
    forever begin
      @(posedge clk); #1;
      ek_done_r  = 1'b0;
      enc_done_r = 1'b0;
      if (reset) begin
        ek_cd  = 0;
        enc_cd = 0;
      end else begin
        if (ek_cd > 0) begin
          ek_cd--;
          if (ek_cd == 0) begin
            ek_done_r = 1'b1;
            eng_done_cyc = cyc;
            if (both_rand && $urandom_range(0, 1) == 1) enc_done_r = 1'b1;
          end
        end
        if (enc_cd > 0) begin
          enc_cd--;
          if (enc_cd == 0) begin
            enc_done_r = 1'b1;
            eng_done_cyc = cyc;
            if (both_rand && $urandom_range(0, 1) == 1) ek_done_r = 1'b1;
          end
        end
        if (bus.ek_start)  ek_cd  = rand_lat ? int'($urandom_range(1, 4)) : lat_fix;
        if (bus.enc_start) enc_cd = rand_lat ? int'($urandom_range(1, 4)) : lat_fix;
      end
    end
  end

  // Monitor: pops expectations on every DUT pulse; every pulse lands 2 cycles after its trigger.
  always @(negedge clk) begin : mon
    int refc;
    int e;
    refc = (start_cyc > eng_done_cyc) ? start_cyc : eng_done_cyc;
    if (!reset) begin
      if (bus.ek_start) begin
        ek_seen++;
        if (exp_ek.size() == 0) flag("ek_start_unexpected");
        else begin
          e = exp_ek.pop_front();
          chk("ek_mode", 32'(bus.ek_mode), 32'(e));
`ifdef BCRYPT_SCHED_PROGRESS_EN
          e = exp_pek.pop_front();
          if (e >= 0) chk("progress_ek", bus.progress, 32'(e));
`endif
        end
        chk("ek_gap", 32'(cyc - refc), 32'd2);
        chk("ek_busy", 32'(bus.busy), 32'd1);
        chk("ek_err", 32'(bus.err), 32'd0);
      end
      if (bus.enc_start) begin
        enc_seen++;
        if (exp_enc.size() == 0) flag("enc_start_unexpected");
        else begin
          e = exp_enc.pop_front();
          chk("enc_block", 32'(bus.enc_block), 32'(e));
`ifdef BCRYPT_SCHED_PROGRESS_EN
          e = exp_penc.pop_front();
          chk("progress_enc", bus.progress, 32'(e));
`endif
        end
        chk("enc_gap", 32'(cyc - refc), 32'd2);
        chk("enc_busy", 32'(bus.busy), 32'd1);
      end
      if (bus.done) begin
        done_seen++;
        if (exp_done.size() == 0) flag("done_unexpected");
        else begin
          e = exp_done.pop_front();
          chk("done_err", 32'(bus.err), 32'(e));
          chk("ek_left_at_done", 32'(exp_ek.size()), 32'd0);
          chk("enc_left_at_done", 32'(exp_enc.size()), 32'd0);
        end
        chk("done_gap", 32'(cyc - refc), 32'd2);
        chk("done_busy", 32'(bus.busy), 32'd0);
`ifdef BCRYPT_SCHED_PROGRESS_EN
        chk("progress_done", bus.progress, 32'd0);
`endif
      end
    end
  end

  // Reference model: the full pulse stream a hash of cost c must produce.
  task automatic expect_run(int c);
    if (c >= 4 && c <= 31) begin
      exp_ek.push_back(0);
`ifdef BCRYPT_SCHED_PROGRESS_EN
      exp_pek.push_back(-1);
`endif
      for (int r = 0; r < (1 << c); r++) begin
        exp_ek.push_back(1);
        exp_ek.push_back(2);
`ifdef BCRYPT_SCHED_PROGRESS_EN
        exp_pek.push_back(r);
        exp_pek.push_back(r);
`endif
      end
      for (int i = 0; i < 64 * 3; i++) begin
        exp_enc.push_back(i % 3);
`ifdef BCRYPT_SCHED_PROGRESS_EN
        exp_penc.push_back((1 << c) + i / 3);
`endif
      end
      exp_done.push_back(0);
    end else begin
      exp_done.push_back(1);
    end
  endtask

  task automatic pulse_start(int c, bit counted);
    start_r = 1'b1;
    cost_r  = 5'(c);
    if (counted) start_cyc = cyc;
    @(posedge clk); #1;
    start_r = 1'b0;
    cost_r  = 5'($urandom);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_done(int target);
    int n = 0;
    while (done_seen < target && n < 8000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_within_budget", 32'(done_seen >= target), 32'd1);
  endtask

  task automatic wait_ek(int target);
    int n = 0;
    while (ek_seen < target && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ek_within_budget", 32'(ek_seen >= target), 32'd1);
  endtask

  task automatic wait_enc(int target);
    int n = 0;
    while (enc_seen < target && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("enc_within_budget", 32'(enc_seen >= target), 32'd1);
  endtask

  task automatic do_reset(bit check);
    reset = 1'b1;
    @(posedge clk); #1;
    if (check) begin
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_err", 32'(bus.err), 32'd0);
      chk("rst_ek_start", 32'(bus.ek_start), 32'd0);
      chk("rst_ek_mode", 32'(bus.ek_mode), 32'd0);
      chk("rst_enc_start", 32'(bus.enc_start), 32'd0);
      chk("rst_enc_block", 32'(bus.enc_block), 32'd0);
`ifdef BCRYPT_SCHED_PROGRESS_EN
      chk("rst_progress", bus.progress, 32'd0);
`endif
    end
    @(posedge clk); #1;
    exp_ek.delete();
    exp_enc.delete();
    exp_done.delete();
`ifdef BCRYPT_SCHED_PROGRESS_EN
    exp_pek.delete();
    exp_penc.delete();
`endif
    reset = 1'b0;
    idle(2);
  endtask

  task automatic run(int c);
    int d0;
    d0 = done_seen;
    expect_run(c);
    pulse_start(c, 1'b1);
    wait_done(d0 + 1);
    idle(3);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation still running at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int b_ek;
    int b_enc;
    int c;
    @(posedge clk); #1;
    do_reset(1'b1);

    // cost 4, engines answer after 3 cycles
    lat_fix = 3;
    run(4);

    // out-of-range cost rejected; err holds afterwards
    run(3);
    chk("err_hold", 32'(bus.err), 32'd1);
    run(int'($urandom_range(0, 3)));

    // cost 31 accepted: first salted expansion issued, then abandoned by reset
    exp_ek.push_back(0);
`ifdef BCRYPT_SCHED_PROGRESS_EN
    exp_pek.push_back(-1);
`endif
    b_ek = ek_seen;
    pulse_start(31, 1'b1);
    wait_ek(b_ek + 1);
    chk("cost31_busy", 32'(bus.busy), 32'd1);
    do_reset(1'b0);

    // cost 5 with single-cycle engines
    lat_fix = 1;
    run(5);

    // ignored restart during KEY_W, stray dones in the wrong wait states
    lat_fix = 3;
    b_ek = ek_seen;
    b_enc = enc_seen;
    expect_run(5);
    pulse_start(5, 1'b1);
    wait_ek(b_ek + 2);
    pulse_start(4, 1'b0);
    wait_ek(b_ek + 3);
    spur_enc = 1'b1;
    @(posedge clk); #1;
    spur_enc = 1'b0;
    wait_enc(b_enc + 1);
    spur_ek = 1'b1;
    @(posedge clk); #1;
    spur_ek = 1'b0;
    wait_done(done_seen + 1);
    chk("restart_ek_total", 32'(ek_seen - b_ek), 32'd65);
    idle(3);

    // reset in ENC_W at pass 10, then a clean run
    b_enc = enc_seen;
    expect_run(4);
    pulse_start(4, 1'b1);
    wait_enc(b_enc + 31);
    do_reset(1'b1);
    run(4);

    // randomized costs, latencies and simultaneous dones
    rand_lat = 1'b1;
    both_rand = 1'b1;
    for (int k = 0; k < 5; k++) begin
      c = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(4, 6));
      run(c);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
